// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared types and constants for the baccarat round controller.
//   card_t          : 4-bit card code (1=A, 2..10, 11=J, 12=Q, 13=K, 0=empty)
//   score_t         : 4-bit hand score 0..9
//   dealer_state_t  : round sequencing states
//   card_value()    : baccarat point value of a card code
// -----------------------------------------------------------------------------
package baccarat_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  typedef enum logic [3:0] {
    DEAL_P1    = 4'd0,
    DEAL_D1    = 4'd1,
    DEAL_P2    = 4'd2,
    DEAL_D2    = 4'd3,
    CHECK_NAT  = 4'd4,
    DEAL_P3    = 4'd5,
    CHECK_BANK = 4'd6,
    DEAL_D3    = 4'd7,
    RESULT     = 4'd8
  } dealer_state_t;

  localparam card_t  CARD_EMPTY    = 4'd0;
  localparam card_t  CARD_FACE_MIN = 4'd10;  // 10, J, Q, K are worth nothing
  localparam score_t NATURAL_MIN   = 4'd8;   // 8 or 9 on two cards ends the round
  localparam score_t DRAW_MAX      = 4'd5;   // highest total that still draws

  // Point value of one card; an empty slot contributes nothing.
  function automatic score_t card_value(input card_t c);
    return (c >= CARD_FACE_MIN) ? 4'd0 : c;
  endfunction

endpackage

// File: rtl/baccarat_draw_rules.sv
// -----------------------------------------------------------------------------
// baccarat_draw_rules
// Banker third-card tableau, purely combinational.
// Ports:
//   dscore      : banker two-card score 0..9
//   pcard3      : player's third card code (ignored when player_drew=0)
//   player_drew : 1 when the player took a third card
//   banker_draw : 1 when the banker must take a third card
// -----------------------------------------------------------------------------
module baccarat_draw_rules
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  input  logic       player_drew,
  output logic       banker_draw
);

  score_t p3v;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    banker_draw = 1'b0;
    p3v         = card_value(pcard3);

    if (!player_drew) begin
      // Player stood: banker follows the same 0..5 draw rule as the player.
      banker_draw = (dscore <= DRAW_MAX);
    end else begin
      unique case (dscore)
        4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
        4'd3:             banker_draw = (p3v != 4'd8);
        4'd4:             banker_draw = (p3v >= 4'd2) && (p3v <= 4'd7);
        4'd5:             banker_draw = (p3v >= 4'd4) && (p3v <= 4'd7);
        4'd6:             banker_draw = (p3v >= 4'd6) && (p3v <= 4'd7);
        default:          banker_draw = 1'b0;  // 7 stands; 8..9 never get here
      endcase
    end
  end

endmodule

// File: rtl/baccarat_hand_scorer.sv
// -----------------------------------------------------------------------------
// baccarat_hand_scorer
// Combinational hand scorer: (v1 + v2 + v3) mod 10.
// Ports:
//   c1, c2, c3 : card codes of one hand (0 = empty slot)
//   score      : hand score 0..9
// -----------------------------------------------------------------------------
module baccarat_hand_scorer
  import baccarat_pkg::*;
(
  input  logic [3:0] c1,
  input  logic [3:0] c2,
  input  logic [3:0] c3,
  output logic [3:0] score
);

  logic [4:0] sum;  // three values of at most 9 each -> 27 max

  always_comb begin
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    // The sum never reaches 30, so two conditional subtractions replace a divider.
    if (sum >= 5'd20) begin
      score = 4'(sum - 5'd20);
    end else if (sum >= 5'd10) begin
      score = 4'(sum - 5'd10);
    end else begin
      score = sum[3:0];
    end
  end

endmodule

// File: rtl/baccarat_dealer_ctrl.sv
// -----------------------------------------------------------------------------
// baccarat_dealer_ctrl
// Sequences one baccarat round: deals player/dealer/player/dealer from a
// valid/ack card source, applies natural and third-card rules, then flags the
// winner. Hand scores are combinational from the six card registers.
//
// Parameters:
//   STEP_GATED  1: a transfer needs step=1 and card_valid=1
//               0: card_valid alone suffices (fast simulation mode)
// Compile-time option:
//   BACCARAT_AUTO_REDEAL_EN  when defined, a step pulse in RESULT clears the
//                            table and restarts at DEAL_P1; otherwise RESULT
//                            is held until resetb.
// Ports:
//   slow_clock, resetb   deal clock, async active-low reset
//   step                 one-cycle advance pulse
//   card_valid, card_in  card source (card_in 0 is never accepted)
//   card_ack             high in the cycle a card is consumed
//   pcard1..3, dcard1..3 player / dealer card registers, 0 = empty
//   pscore, dscore       hand scores 0..9
//   player_win, dealer_win  outcome, both high on a tie
//   done                 round complete
// -----------------------------------------------------------------------------
module baccarat_dealer_ctrl
  import baccarat_pkg::*;
#(
  parameter bit STEP_GATED = 1'b1
)
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  output logic       card_ack,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  dealer_state_t state_q, state_d;
  logic          in_deal;
  logic          banker_draw;
  logic          player_drew;
  logic          redeal;

  // ---------------------------------------------------------------------------
  // Scoring and tableau
  // ---------------------------------------------------------------------------
  baccarat_hand_scorer u_player_score (
    .c1    (pcard1),
    .c2    (pcard2),
    .c3    (pcard3),
    .score (pscore)
  );

  baccarat_hand_scorer u_dealer_score (
    .c1    (dcard1),
    .c2    (dcard2),
    .c3    (dcard3),
    .score (dscore)
  );

  // Codes are never 0 once dealt, so a filled pcard3 means the player drew.
  assign player_drew = (pcard3 != CARD_EMPTY);

  baccarat_draw_rules u_draw_rules (
    .dscore      (dscore),
    .pcard3      (pcard3),
    .player_drew (player_drew),
    .banker_draw (banker_draw)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge slow_clock or negedge resetb) begin
    // NOTE: clocked blocks use non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (!resetb) begin
      state_q <= DEAL_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DEAL_P1: if (card_ack) state_d = DEAL_D1;
      DEAL_D1: if (card_ack) state_d = DEAL_P2;
      DEAL_P2: if (card_ack) state_d = DEAL_D2;
      DEAL_D2: if (card_ack) state_d = CHECK_NAT;
      CHECK_NAT: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          state_d = RESULT;
        end else if (pscore <= DRAW_MAX) begin
          state_d = DEAL_P3;
        end else begin
          state_d = CHECK_BANK;  // player stands, pcard3 stays empty
        end
      end
      DEAL_P3:    if (card_ack) state_d = CHECK_BANK;
      CHECK_BANK: state_d = banker_draw ? DEAL_D3 : RESULT;
      DEAL_D3:    if (card_ack) state_d = RESULT;
      RESULT:     if (redeal) state_d = DEAL_P1;
      default:    state_d = DEAL_P1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_deal  = state_q inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DEAL_P3, DEAL_D3};
    // A zero code is refused outright so an empty slot can never be "dealt".
    card_ack = in_deal && card_valid && (card_in != CARD_EMPTY) && (step || !STEP_GATED);
`ifdef BACCARAT_AUTO_REDEAL_EN
    redeal   = (state_q == RESULT) && step;
`else
    redeal   = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Card registers: the slot is selected by the state the transfer happens in.
  // ---------------------------------------------------------------------------
  always_ff @(posedge slow_clock or negedge resetb) begin
    // NOTE: only six small registers, and they drive the display directly, so
    // all of them are reset rather than relying on a valid flag.
    if (!resetb) begin
      pcard1 <= CARD_EMPTY;
      pcard2 <= CARD_EMPTY;
      pcard3 <= CARD_EMPTY;
      dcard1 <= CARD_EMPTY;
      dcard2 <= CARD_EMPTY;
      dcard3 <= CARD_EMPTY;
    end else if (redeal) begin
      pcard1 <= CARD_EMPTY;
      pcard2 <= CARD_EMPTY;
      pcard3 <= CARD_EMPTY;
      dcard1 <= CARD_EMPTY;
      dcard2 <= CARD_EMPTY;
      dcard3 <= CARD_EMPTY;
    end else if (card_ack) begin
      unique case (state_q)
        DEAL_P1: pcard1 <= card_in;
        DEAL_D1: dcard1 <= card_in;
        DEAL_P2: pcard2 <= card_in;
        DEAL_D2: dcard2 <= card_in;
        DEAL_P3: pcard3 <= card_in;
        DEAL_D3: dcard3 <= card_in;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outcome: captured on the first RESULT clock, once the last dealt card is
  // already reflected in the scores; done then blocks any re-capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      done       <= 1'b0;
    end else if (redeal) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      done       <= 1'b0;
    end else if ((state_q == RESULT) && !done) begin
      player_win <= (pscore >= dscore);
      dealer_win <= (dscore >= pscore);
      done       <= 1'b1;
    end
  end

  a_done_only_in_result : assert property (
    @(posedge slow_clock) disable iff (!resetb) done |-> (state_q == RESULT)
  );

endmodule
